mux_gate_bist: RTL

- Built-in self-test sequencer that wraps the 2x1-mux logic-gate array (NOT/AND/OR/NAND/NOR/XOR/XNOR on y1..y7).
- Upstream side: drives the array's a and b inputs through all four combinations.
- Downstream side: consumes the seven gate outputs, checks each against a golden truth table, and reports per-gate pass/fail.
- Sits between a top-level test controller (start/done handshake) and the combinational gate array.

---
 rtl/mux_gate_pkg.sv | 23 ++
 rtl/mux_gate_bist_gate_ref_model.sv | 22 ++
 rtl/mux_gate_bist.sv | 117 +++++++++++
 3 files changed

// File: rtl/mux_gate_pkg.sv
// Shared types and constants for the 2x1-mux gate-array BIST sequencer.
package mux_gate_pkg;

    localparam int unsigned NUM_GATES = 7;
    localparam int unsigned SETTLE_W  = 4;

    localparam int unsigned GATE_NOT  = 0;
    localparam int unsigned GATE_AND  = 1;
    localparam int unsigned GATE_OR   = 2;
    localparam int unsigned GATE_NAND = 3;
    localparam int unsigned GATE_NOR  = 4;
    localparam int unsigned GATE_XOR  = 5;
    localparam int unsigned GATE_XNOR = 6;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StCheck,
        StDone
    } state_e;

endpackage

// File: rtl/mux_gate_bist_gate_ref_model.sv
// Golden truth table for the gate array, written as plain boolean operators so the
// check does not share structure with the mux-based implementation under test.
module gate_ref_model
    import mux_gate_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] expected
);

    always_comb begin
        expected            = '0;
        expected[GATE_NOT]  = ~a;
        expected[GATE_AND]  = a & b;
        expected[GATE_OR]   = a | b;
        expected[GATE_NAND] = ~(a & b);
        expected[GATE_NOR]  = ~(a | b);
        expected[GATE_XOR]  = a ^ b;
        expected[GATE_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/mux_gate_bist.sv
// BIST sequencer: walks {a,b} through 00..11, waits for the array to settle, and
// accumulates per-gate mismatches against the golden model.
module mux_gate_bist
    import mux_gate_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 a_out,
    output logic                 b_out,
    input  logic [NUM_GATES-1:0] y_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] fail_mask,
    output logic [1:0]           first_fail_vec
);

    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] CNT_ONE     = SETTLE_W'(1);

    state_e                state_q, state_d;
    logic [1:0]            combo_q, combo_d;
    logic [SETTLE_W-1:0]   cnt_q, cnt_d;
    logic [NUM_GATES-1:0]  fail_mask_q, fail_mask_d;
    logic [1:0]            first_q, first_d;
    logic                  pass_q, pass_d;
    logic [NUM_GATES-1:0]  expected;
    logic [NUM_GATES-1:0]  mismatch;

    gate_ref_model u_ref (
        .a        (combo_q[1]),
        .b        (combo_q[0]),
        .expected (expected)
    );

    assign mismatch = y_in ^ expected;

    always_comb begin
        state_d     = state_q;
        combo_d     = combo_q;
        cnt_d       = cnt_q;
        fail_mask_d = fail_mask_q;
        first_d     = first_q;
        pass_d      = pass_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    fail_mask_d = '0;
                    first_d     = '0;
                    pass_d      = 1'b0;
                    combo_d     = '0;
                    state_d     = StDrive;
                end
            end
            StDrive: begin
                cnt_d   = SETTLE_INIT;
                state_d = (SETTLE_CYCLES == 0) ? StCheck : StSettle;
            end
            StSettle: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                fail_mask_d = fail_mask_q | mismatch;
                if ((mismatch != '0) && (fail_mask_q == '0)) begin
                    first_d = combo_q;
                end
                if (combo_q == 2'd3) begin
                    // Result is published with the done pulse, so fold in this last check.
                    pass_d  = (fail_mask_d == '0);
                    state_d = StDone;
                end else begin
                    combo_d = combo_q + 2'd1;
                    state_d = StDrive;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            combo_q     <= '0;
            cnt_q       <= '0;
            fail_mask_q <= '0;
            first_q     <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            combo_q     <= combo_d;
            cnt_q       <= cnt_d;
            fail_mask_q <= fail_mask_d;
            first_q     <= first_d;
            pass_q      <= pass_d;
        end
    end

    assign a_out          = combo_q[1];
    assign b_out          = combo_q[0];
    assign busy           = (state_q == StDrive) || (state_q == StSettle) || (state_q == StCheck);
    assign done           = (state_q == StDone);
    assign pass           = pass_q;
    assign fail_mask      = fail_mask_q;
    assign first_fail_vec = first_q;

endmodule
